// File: rtl/lcd_cmd_scheduler_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : lcd_pkg                                                    |
// | Description : Shared command codes, init ROM order and FSM state type    |
// |               for the HD44780 command scheduler.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lcd_pkg;

  localparam logic [7:0] CMD_FUNCSET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISPON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_ENTRY   = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_CLEAR   = 8'h01;  // clear display

  localparam logic [1:0] INIT_LAST_IDX = 2'd3;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    INIT  = 3'd1,
    IDLE  = 3'd2,
    SETUP = 3'd3,
    EN_HI = 3'd4,
    HOLD  = 3'd5,
    WAIT  = 3'd6
  } lcd_state_t;

  // Init ROM: the fixed power-up command order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNCSET;
      2'd1:    cmd = CMD_DISPON;
      2'd2:    cmd = CMD_ENTRY;
      default: cmd = CMD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Clear (0x01) and home (0x02/0x03) are the slow instructions: a command
  // write whose upper six bits are all zero.
  function automatic logic is_long_cmd(input logic rs, input logic [5:0] data_hi);
    return (rs == 1'b0) && (data_hi == 6'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : lcd_cmd_scheduler_if                                       |
// | Description : Two-port request/grant bundle between the LCD requesters   |
// |               (keyboard writer A, maintenance B) and the scheduler.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface lcd_cmd_scheduler_if;

  logic       req_a;
  logic       rs_a;
  logic [7:0] data_a;
  logic       gnt_a;

  logic       req_b;
  logic       rs_b;
  logic [7:0] data_b;
  logic       gnt_b;

  // Requesters drive req/rs/data and watch for their grant pulse.
  modport master (
    output req_a, rs_a, data_a,
    output req_b, rs_b, data_b,
    input  gnt_a, gnt_b
  );

  // The scheduler samples requests and returns one-cycle grants.
  modport slave (
    input  req_a, rs_a, data_a,
    input  req_b, rs_b, data_b,
    output gnt_a, gnt_b
  );

endinterface
`default_nettype wire

// File: rtl/lcd_cmd_scheduler_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_rr_arbiter                                             |
// | Description : Two-port round-robin arbiter. The winner is combinational  |
// |               from the requests and a last-grant priority register.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lcd_rr_arbiter (
  input  wire logic clk,
  input  wire logic rst,     // asynchronous, active-low
  input  wire logic arb_en,  // scheduler is free to accept a command
  input  wire logic req_a,
  input  wire logic req_b,
  output logic      win_a,
  output logic      win_b
);

  // 0: A has priority on a tie, 1: B has priority (A was granted last).
  logic r_prio_b;

  // Winner select: a lone requester always wins; a tie goes to the priority side.
  always_comb begin
    win_a = arb_en & req_a & (~req_b | ~r_prio_b);
    win_b = arb_en & req_b & (~req_a |  r_prio_b);
  end

  // Hand priority to the port that did not just win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio_b <= 1'b0;
    end else if (win_a) begin
      r_prio_b <= 1'b1;
    end else if (win_b) begin
      r_prio_b <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lcd_cmd_scheduler                                          |
// | Description : HD44780 bus sequencer. Runs power-up delay and init ROM,   |
// |               then round-robins two requesters onto the LCD bus with     |
// |               programmable setup / enable / busy-wait timing.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC     = 750000,
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 25,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  wire logic          clk,
  input  wire logic          rst,        // asynchronous, active-low
  lcd_cmd_scheduler_if.slave bus,
  output logic               busy,
  output logic               init_done,
  output logic [7:0]         lcd_data,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en,
  output logic               lcd_on
);

  // One down-counter covers every delay, so it is sized for the longest one.
  localparam int MAX_AB  = (PWRUP_CYC > LONG_WAIT_CYC) ? PWRUP_CYC : LONG_WAIT_CYC;
  localparam int MAX_CD  = (WAIT_CYC > EN_CYC) ? WAIT_CYC : EN_CYC;
  localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_CYC = (MAX_ABC > SETUP_CYC) ? MAX_ABC : SETUP_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] c_pwrup_ld = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0] c_setup_ld = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] c_en_ld    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] c_wait_ld  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] c_long_ld  = CW'(LONG_WAIT_CYC - 1);

  lcd_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_init_idx;
  logic          w_arb_en;
  logic          w_win_a;
  logic          w_win_b;

  // The bus is write-only.
  assign lcd_rw   = 1'b0;
  assign w_arb_en = (r_state == IDLE);

  lcd_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .arb_en (w_arb_en),
    .req_a  (bus.req_a),
    .req_b  (bus.req_b),
    .win_a  (w_win_a),
    .win_b  (w_win_b)
  );

  // Main sequencer: state, delay counter and every registered bus output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= PWRUP;
      r_cnt      <= c_pwrup_ld;
      r_init_idx <= 2'd0;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_on     <= 1'b0;
      bus.gnt_a  <= 1'b0;
      bus.gnt_b  <= 1'b0;
      busy       <= 1'b1;
      init_done  <= 1'b0;
    end else begin
      lcd_on    <= 1'b1;
      bus.gnt_a <= 1'b0;
      bus.gnt_b <= 1'b0;
      // Free-running decrement; each state transition reloads below.
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      case (r_state)
        PWRUP: begin
          if (r_cnt == '0) begin
            r_state <= INIT;
          end
        end

        INIT: begin
          lcd_data <= init_cmd(r_init_idx);
          lcd_rs   <= 1'b0;
          r_cnt    <= c_setup_ld;
          r_state  <= SETUP;
        end

        IDLE: begin
          if (w_win_a || w_win_b) begin
            bus.gnt_a <= w_win_a;
            bus.gnt_b <= w_win_b;
            lcd_data  <= w_win_a ? bus.data_a : bus.data_b;
            lcd_rs    <= w_win_a ? bus.rs_a   : bus.rs_b;
            busy      <= 1'b1;
            r_cnt     <= c_setup_ld;
            r_state   <= SETUP;
          end
        end

        SETUP: begin
          if (r_cnt == '0) begin
            lcd_en  <= 1'b1;
            r_cnt   <= c_en_ld;
            r_state <= EN_HI;
          end
        end

        EN_HI: begin
          if (r_cnt == '0) begin
            lcd_en  <= 1'b0;
            r_state <= HOLD;
          end
        end

        HOLD: begin
          r_cnt   <= is_long_cmd(lcd_rs, lcd_data[7:2]) ? c_long_ld : c_wait_ld;
          r_state <= WAIT;
        end

        WAIT: begin
          if (r_cnt == '0) begin
            if (init_done) begin
              busy    <= 1'b0;
              r_state <= IDLE;
            end else if (r_init_idx == INIT_LAST_IDX) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_init_idx <= r_init_idx + 2'd1;
              r_state    <= INIT;
            end
          end
        end

        default: begin
          lcd_en  <= 1'b0;
          r_cnt   <= c_pwrup_ld;
          r_state <= PWRUP;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lcd_cmd_scheduler                                       |
// | Description : Directed, table-driven bench for lcd_cmd_scheduler.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_lcd_cmd_scheduler;
  import lcd_pkg::*;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;

  lcd_cmd_scheduler_if bus ();

  lcd_cmd_scheduler #(
    .PWRUP_CYC     (20),
    .SETUP_CYC     (2),
    .EN_CYC        (4),
    .WAIT_CYC      (10),
    .LONG_WAIT_CYC (40)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .init_done (init_done),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_on    (lcd_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Enable-pulse monitor: one record per en pulse, stamped in negedge cycles.
  typedef struct {
    int         rise;
    int         fall;
    logic [7:0] data;
    logic       rs;
  } pulse_t;

  pulse_t pq[$];
  pulse_t mon_p;
  int     cyc     = 0;
  logic   prev_en = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (lcd_en && !prev_en) begin
      mon_p.rise = cyc;
      mon_p.fall = -1;
      mon_p.data = lcd_data;
      mon_p.rs   = lcd_rs;
      pq.push_back(mon_p);
    end
    if (!lcd_en && prev_en && pq.size() > 0) begin
      pq[pq.size()-1].fall = cyc;
    end
    prev_en = lcd_en;
  end

  typedef struct {
    logic       port_b;
    logic       rs;
    logic [7:0] data;
    int         exp_busy;
  } vec_t;

  vec_t       vt[6];
  logic [7:0] exp_init[4];
  logic       exp_rr[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int t);
    t = 0;
    while (!(bus.gnt_a || bus.gnt_b) && t < 400) begin
      step();
      t++;
    end
    check("gnt_within_bound", (t < 400), 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 400) begin
      step();
      t++;
    end
    check("idle_within_bound", busy, 0);
  endtask

  // Waits for init_done; flags any grant seen before it.
  task automatic wait_init(output int done_cyc, output logic early);
    int t;
    t     = 0;
    early = 1'b0;
    while (!init_done && t < 1000) begin
      step();
      t++;
      if ((bus.gnt_a || bus.gnt_b) && !init_done) early = 1'b1;
    end
    done_cyc = cyc;
  endtask

  task automatic check_init(input int q0, input int done_cyc);
    check("init_pulse_count", pq.size() - q0, 4);
    if (pq.size() - q0 >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("init_data", pq[q0+i].data, exp_init[i]);
        check("init_rs", pq[q0+i].rs, 0);
        check("init_en_len", pq[q0+i].fall - pq[q0+i].rise, 4);
      end
      // HOLD (1) + long wait (40) after the clear command
      check("init_clear_gap", done_cyc - pq[q0+3].fall, 41);
    end
    check("init_done_set", init_done, 1);
    check("busy_after_init", busy, 0);
  endtask

  task automatic do_txn(input vec_t v);
    int t;
    int n;
    int b;
    if (v.port_b) begin
      bus.req_b = 1'b1; bus.rs_b = v.rs; bus.data_b = v.data;
    end else begin
      bus.req_a = 1'b1; bus.rs_a = v.rs; bus.data_a = v.data;
    end
    t = 0;
    while (!(bus.gnt_a || bus.gnt_b) && t < 100) begin
      step();
      t++;
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    check("grant_latency", t, 1);
    check("gnt_a", bus.gnt_a, !v.port_b);
    check("gnt_b", bus.gnt_b, v.port_b);
    check("lcd_data", lcd_data, v.data);
    check("lcd_rs", lcd_rs, v.rs);
    check("busy_at_gnt", busy, 1);
    step();
    check("gnt_one_cycle", {bus.gnt_a, bus.gnt_b}, 0);
    t = 1;
    while (!lcd_en && t < 50) begin
      step();
      t++;
    end
    check("en_rise_after_gnt", t, 2);
    n = 0;
    while (lcd_en && n < 50) begin
      n++;
      step();
    end
    check("en_high_cycles", n, 4);
    b = t + n;
    while (busy && b < 200) begin
      b++;
      step();
    end
    check("busy_cycles", b, v.exp_busy);
    check("data_held", lcd_data, v.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   q0;
    int   last;
    int   done_cyc;
    logic early;

    // port_b, rs, data, expected busy cycles (2 setup + 4 en + 1 hold + wait)
    vt[0] = '{1'b0, 1'b1, 8'h41, 17};
    vt[1] = '{1'b1, 1'b0, 8'h01, 47};
    vt[2] = '{1'b1, 1'b0, 8'hC0, 17};
    vt[3] = '{1'b0, 1'b0, 8'h02, 47};
    vt[4] = '{1'b0, 1'b0, 8'h04, 17};
    vt[5] = '{1'b1, 1'b1, 8'h03, 17};
    exp_init = '{8'h38, 8'h0C, 8'h06, 8'h01};
    exp_rr   = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0;
    bus.req_a = 1'b0; bus.rs_a = 1'b0; bus.data_a = 8'h00;
    bus.req_b = 1'b0; bus.rs_b = 1'b0; bus.data_b = 8'h00;

    // Reset state
    step();
    step();
    check("rst_lcd_data", lcd_data, 8'h00);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_rw", lcd_rw, 0);
    check("rst_lcd_en", lcd_en, 0);
    check("rst_lcd_on", lcd_on, 0);
    check("rst_gnt", {bus.gnt_a, bus.gnt_b}, 0);
    check("rst_busy", busy, 1);
    check("rst_init_done", init_done, 0);

    // Power-up and init with no requests
    rst = 1'b1;
    step();
    check("lcd_on_after_release", lcd_on, 1);
    q0 = pq.size();
    wait_init(done_cyc, early);
    check("no_gnt_during_init", early, 0);
    check_init(q0, done_cyc);

    // Single-command vectors
    for (int i = 0; i < 6; i++) begin
      do_txn(vt[i]);
    end

    // Contested requests held across four grants
    bus.req_a = 1'b1; bus.rs_a = 1'b1; bus.data_a = 8'h61;
    bus.req_b = 1'b1; bus.rs_b = 1'b1; bus.data_b = 8'h62;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(t);
      check("rr_gnt_b", bus.gnt_b, exp_rr[i]);
      check("rr_gnt_a", bus.gnt_a, !exp_rr[i]);
      check("rr_data", lcd_data, exp_rr[i] ? 8'h62 : 8'h61);
      if (i > 0) check("rr_spacing", cyc - last, 18);
      last = cyc;
      step();
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    wait_idle();

    // Reset asserted in the middle of the enable pulse
    bus.req_b = 1'b1; bus.rs_b = 1'b1; bus.data_b = 8'h48;
    wait_gnt(t);
    bus.req_b = 1'b0;
    t = 0;
    while (!lcd_en && t < 50) begin
      step();
      t++;
    end
    step();
    check("en_high_before_rst", lcd_en, 1);
    #1 rst = 1'b0;
    #1;
    check("rst_async_en", lcd_en, 0);
    check("rst_async_on", lcd_on, 0);
    check("rst_async_data", lcd_data, 8'h00);
    check("rst_async_busy", busy, 1);
    check("rst_async_init_done", init_done, 0);
    step();
    step();

    // Rerun of init with port A requesting during power-up
    q0 = pq.size();
    bus.req_a = 1'b1; bus.rs_a = 1'b1; bus.data_a = 8'h55;
    rst = 1'b1;
    wait_init(done_cyc, early);
    check("no_gnt_before_init_done", early, 0);
    check_init(q0, done_cyc);
    step();
    check("pwrup_req_gnt_a", bus.gnt_a, 1);
    check("pwrup_req_gnt_b", bus.gnt_b, 0);
    check("pwrup_req_data", lcd_data, 8'h55);
    bus.req_a = 1'b0;

    // First contested grant after a fresh reset goes to A
    step();
    rst = 1'b0;
    step();
    step();
    bus.req_a = 1'b1; bus.rs_a = 1'b1; bus.data_a = 8'h71;
    bus.req_b = 1'b1; bus.rs_b = 1'b1; bus.data_b = 8'h72;
    rst = 1'b1;
    wait_gnt(t);
    check("first_tie_gnt_a", bus.gnt_a, 1);
    check("first_tie_gnt_b", bus.gnt_b, 0);
    step();
    wait_gnt(t);
    check("second_tie_gnt_b", bus.gnt_b, 1);
    check("second_tie_data", lcd_data, 8'h72);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
